// File: rtl/phase_pkg.sv
// Shared definitions for the phase sequencer: phase indices, FSM encoding and
// a one-hot-to-index helper.
package phase_pkg;

  localparam int unsigned MaxPhase = 16;
  localparam int unsigned IdxW     = 4;

  // Phase indices for the default five-phase build.
  localparam int unsigned F = 0;
  localparam int unsigned R = 1;
  localparam int unsigned X = 2;
  localparam int unsigned M = 3;
  localparam int unsigned W = 4;

  typedef enum logic [1:0] {
    StRun      = 2'd0,
    StWaitStep = 2'd1,
    StHalted   = 2'd2
  } state_e;

  // Index of the set bit; returns 0 for an all-zero vector.
  function automatic logic [IdxW-1:0] onehot_idx(input logic [MaxPhase-1:0] v);
    logic [IdxW-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < MaxPhase; i++) begin
      if (v[i]) idx = IdxW'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/phase_seq_if.sv
// Control/status bundle between the phase sequencer and its driver.
interface phase_seq_if #(
  parameter int unsigned NPHASE = 5,
  parameter int unsigned CNT_W  = 32
);
  logic              HLT;
  logic              STALL;
  logic [NPHASE-1:0] SKIP;
  logic              STEP_EN;
  logic              STEP;
  logic [NPHASE-1:0] phase;
  logic              halted;
  logic              retire;
  logic [CNT_W-1:0]  icount;
  logic [CNT_W-1:0]  cycle_cnt;

  modport master (
    output HLT, STALL, SKIP, STEP_EN, STEP,
    input  phase, halted, retire, icount, cycle_cnt
  );

  modport slave (
    input  HLT, STALL, SKIP, STEP_EN, STEP,
    output phase, halted, retire, icount, cycle_cnt
  );
endinterface

// File: rtl/phase_next_sel.sv
// Combinational next-phase search: lowest unskipped phase above the current one,
// or a wrap back to fetch when none remains.
module phase_next_sel
  import phase_pkg::*;
#(
  parameter int unsigned NPHASE = 5
) (
  input  logic [NPHASE-1:0] cur_i,
  input  logic [NPHASE-1:0] skip_i,
  output logic [NPHASE-1:0] nxt_o,
  output logic              wrap_o
);

  logic [MaxPhase-1:0] cur_ext;
  logic [IdxW-1:0]     cur_idx;
  logic                found;
  logic                unused_skip0;

  // Fetch is never skipped, so bit 0 of the mask plays no part.
  assign unused_skip0 = skip_i[0];

  always_comb begin
    cur_ext = '0;
    cur_ext[NPHASE-1:0] = cur_i;
  end

  assign cur_idx = onehot_idx(cur_ext);

  always_comb begin
    nxt_o  = '0;
    found  = 1'b0;
    for (int unsigned i = 1; i < NPHASE; i++) begin
      if (!found && (i > {28'd0, cur_idx}) && !skip_i[i]) begin
        nxt_o[i] = 1'b1;
        found    = 1'b1;
      end
    end
    wrap_o = !found;
    if (!found) nxt_o[F] = 1'b1;
  end

endmodule

// File: rtl/phase_seq.sv
// One-hot phase sequencer with per-instruction skipping, stall, boundary halt,
// single-step and retire/cycle counters.
module phase_seq
  import phase_pkg::*;
#(
  parameter int unsigned NPHASE = 5,
  parameter int unsigned CNT_W  = 32
) (
  input logic        CLK,
  input logic        RST,
  phase_seq_if.slave bus
);

  state_e            state_q, state_d;
  logic [NPHASE-1:0] phase_q, phase_d;
  logic              retire_q, retire_d;
  logic [CNT_W-1:0]  icount_q, icount_d;
  logic [CNT_W-1:0]  cycle_q, cycle_d;

  logic [NPHASE-1:0] fetch_oh;
  logic [NPHASE-1:0] nxt_phase;
  logic              wrap;
  logic              advance;

  always_comb begin
    fetch_oh    = '0;
    fetch_oh[F] = 1'b1;
  end

  phase_next_sel #(
    .NPHASE (NPHASE)
  ) u_next_sel (
    .cur_i  (phase_q),
    .skip_i (bus.SKIP),
    .nxt_o  (nxt_phase),
    .wrap_o (wrap)
  );

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    retire_d = 1'b0;
    icount_d = icount_q;
    cycle_d  = (state_q != StHalted) ? cycle_q + CNT_W'(1) : cycle_q;
    advance  = 1'b0;

    unique case (state_q)
      StRun: advance = !bus.STALL;
      // Parked on fetch, which is itself an instruction boundary.
      StWaitStep: begin
        if (!bus.STALL) begin
          if (bus.HLT) begin
            state_d = StHalted;
            phase_d = '0;
          end else if (!bus.STEP_EN) begin
            state_d = StRun;
          end else begin
            advance = bus.STEP;
          end
        end
      end
      StHalted: begin
        if (!bus.HLT) begin
          state_d = bus.STEP_EN ? StWaitStep : StRun;
          phase_d = fetch_oh;
        end
      end
      default: begin
        state_d = StRun;
        phase_d = fetch_oh;
      end
    endcase

    if (advance) begin
      if (wrap) begin
        retire_d = 1'b1;
        icount_d = icount_q + CNT_W'(1);
        if (bus.HLT) begin
          state_d = StHalted;
          phase_d = '0;
        end else if (bus.STEP_EN) begin
          state_d = StWaitStep;
          phase_d = fetch_oh;
        end else begin
          state_d = StRun;
          phase_d = fetch_oh;
        end
      end else begin
        state_d = StRun;
        phase_d = nxt_phase;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= StRun;
      phase_q  <= fetch_oh;
      retire_q <= 1'b0;
      icount_q <= '0;
      cycle_q  <= '0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      retire_q <= retire_d;
      icount_q <= icount_d;
      cycle_q  <= cycle_d;
    end
  end

  assign bus.phase     = phase_q;
  assign bus.halted    = (state_q == StHalted);
  assign bus.retire    = retire_q;
  assign bus.icount    = icount_q;
  assign bus.cycle_cnt = cycle_q;

endmodule

// File: tb/tb_phase_seq.sv
// Directed bench for phase_seq: a vector table for the phase/retire/halt flow,
// then hand sequences for counters, reset override and the narrow build.
module tb_phase_seq;

  logic clk;
  logic rst;

  phase_seq_if #(.NPHASE(5), .CNT_W(32)) bus ();
  phase_seq_if #(.NPHASE(3), .CNT_W(4))  sbus ();

  phase_seq #(.NPHASE(5), .CNT_W(32)) u_dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  phase_seq #(.NPHASE(3), .CNT_W(4)) u_small (
    .CLK (clk),
    .RST (rst),
    .bus (sbus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       hlt;
    logic       stall;
    logic [4:0] skip;
    logic       sen;
    logic       step;
    logic [4:0] ph;
    logic       hl;
    logic       rt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic hlt, input logic stall, input logic [4:0] skip,
                     input logic sen, input logic step, input logic [4:0] ph,
                     input logic hl, input logic rt);
    vec_t v;
    v.hlt = hlt; v.stall = stall; v.skip = skip; v.sen = sen; v.step = step;
    v.ph = ph; v.hl = hl; v.rt = rt;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.HLT = 0; bus.STALL = 0; bus.SKIP = '0; bus.STEP_EN = 0; bus.STEP = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Phase invariant, checked every cycle away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      n_checks++;
      if (!($onehot(bus.phase) || (bus.halted && bus.phase == '0))) begin
        n_fail++;
        $display("FAIL onehot: phase %b halted %b", bus.phase, bus.halted);
      end
      n_checks++;
      if (!($onehot(sbus.phase) || (sbus.halted && sbus.phase == '0))) begin
        n_fail++;
        $display("FAIL onehot_small: phase %b halted %b", sbus.phase, sbus.halted);
      end
    end
  end

  initial begin
    int rcnt;
    rst = 1'b1;
    idle_inputs();
    sbus.HLT = 0; sbus.STALL = 0; sbus.SKIP = '0; sbus.STEP_EN = 0; sbus.STEP = 0;

    // hlt stall skip sen step -> phase halted retire
    add(0,0,5'b00000,0,0, 5'b00010,0,0);
    add(0,0,5'b00000,0,0, 5'b00100,0,0);
    add(0,0,5'b00000,0,0, 5'b01000,0,0);
    add(0,0,5'b00000,0,0, 5'b10000,0,0);
    add(0,0,5'b00000,0,0, 5'b00001,0,1);
    add(0,0,5'b01000,0,0, 5'b00010,0,0);
    add(0,0,5'b01000,0,0, 5'b00100,0,0);
    add(0,0,5'b01000,0,0, 5'b10000,0,0);
    add(0,0,5'b01000,0,0, 5'b00001,0,1);
    add(0,0,5'b11110,0,0, 5'b00001,0,1);
    add(0,0,5'b11110,0,0, 5'b00001,0,1);
    add(0,0,5'b00000,0,0, 5'b00010,0,0);
    add(0,0,5'b00000,0,0, 5'b00100,0,0);
    add(0,1,5'b00000,0,0, 5'b00100,0,0);
    add(0,1,5'b00000,0,0, 5'b00100,0,0);
    add(0,1,5'b00000,0,0, 5'b00100,0,0);
    add(0,0,5'b00000,0,0, 5'b01000,0,0);
    add(0,0,5'b00000,0,0, 5'b10000,0,0);
    add(0,1,5'b00000,0,0, 5'b10000,0,0);
    add(0,0,5'b00000,0,0, 5'b00001,0,1);
    add(0,0,5'b00000,0,0, 5'b00010,0,0);
    add(0,0,5'b11000,0,0, 5'b00100,0,0);
    add(0,0,5'b11000,0,0, 5'b00001,0,1);
    add(0,0,5'b00000,0,0, 5'b00010,0,0);
    add(1,0,5'b00000,0,0, 5'b00100,0,0);
    add(1,0,5'b00000,0,0, 5'b01000,0,0);
    add(1,0,5'b00000,0,0, 5'b10000,0,0);
    add(1,0,5'b00000,0,0, 5'b00000,1,1);
    add(1,1,5'b11110,0,1, 5'b00000,1,0);
    add(0,0,5'b00000,0,0, 5'b00001,0,0);
    add(1,1,5'b11110,0,0, 5'b00001,0,0);
    add(1,0,5'b11110,0,0, 5'b00000,1,1);
    add(0,0,5'b00000,1,0, 5'b00001,0,0);
    add(0,0,5'b00000,1,0, 5'b00001,0,0);
    add(0,0,5'b00000,1,1, 5'b00010,0,0);
    add(0,0,5'b00000,1,0, 5'b00100,0,0);
    add(0,0,5'b00000,1,0, 5'b01000,0,0);
    add(0,0,5'b00000,1,0, 5'b10000,0,0);
    add(0,0,5'b00000,1,0, 5'b00001,0,1);
    add(0,0,5'b00000,1,0, 5'b00001,0,0);
    add(1,0,5'b00000,1,0, 5'b00000,1,0);
    add(0,0,5'b00000,1,0, 5'b00001,0,0);
    add(0,1,5'b00000,1,1, 5'b00001,0,0);
    add(0,0,5'b00000,0,0, 5'b00001,0,0);
    add(0,0,5'b00000,0,0, 5'b00010,0,0);
    add(0,0,5'b00000,0,1, 5'b00100,0,0);

    // Reset state
    do_reset();
    check("rst_phase", 64'(bus.phase), 64'd1);
    check("rst_halted", 64'(bus.halted), 64'd0);
    check("rst_retire", 64'(bus.retire), 64'd0);
    check("rst_icount", 64'(bus.icount), 64'd0);
    check("rst_cycle", 64'(bus.cycle_cnt), 64'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      bus.HLT = tbl[i].hlt; bus.STALL = tbl[i].stall; bus.SKIP = tbl[i].skip;
      bus.STEP_EN = tbl[i].sen; bus.STEP = tbl[i].step;
      tick();
      check($sformatf("vec%0d_phase", i), 64'(bus.phase), 64'(tbl[i].ph));
      check($sformatf("vec%0d_halted", i), 64'(bus.halted), 64'(tbl[i].hl));
      check($sformatf("vec%0d_retire", i), 64'(bus.retire), 64'(tbl[i].rt));
    end

    // 20 cycles of full instructions: retire on cycles 5,10,15,20
    idle_inputs();
    do_reset();
    rcnt = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (bus.retire) rcnt++;
      check($sformatf("run_retire_c%0d", c), 64'(bus.retire), 64'((c % 5) == 0));
    end
    check("run_icount", 64'(bus.icount), 64'd4);
    check("run_cycle", 64'(bus.cycle_cnt), 64'd20);
    check("run_rcnt", 64'(rcnt), 64'd4);

    // Stall still counts cycles
    bus.STALL = 1;
    repeat (3) tick();
    check("stall_cycle", 64'(bus.cycle_cnt), 64'd23);
    check("stall_icount", 64'(bus.icount), 64'd4);
    bus.STALL = 0;

    // Halt freezes cycle_cnt; resume takes one uncounted cycle
    do_reset();
    bus.HLT = 1;
    repeat (5) tick();
    check("hlt_halted", 64'(bus.halted), 64'd1);
    check("hlt_cycle", 64'(bus.cycle_cnt), 64'd5);
    repeat (3) tick();
    check("hlt_cycle_frozen", 64'(bus.cycle_cnt), 64'd5);
    check("hlt_icount", 64'(bus.icount), 64'd1);
    bus.HLT = 0;
    tick();
    check("resume_phase", 64'(bus.phase), 64'd1);
    check("resume_cycle", 64'(bus.cycle_cnt), 64'd5);
    tick();
    check("resume_cycle2", 64'(bus.cycle_cnt), 64'd6);

    // Single-step: parks after first instruction, no advance while idle
    do_reset();
    bus.STEP_EN = 1;
    repeat (5) tick();
    for (int c = 0; c < 10; c++) begin
      tick();
      check($sformatf("park_phase_%0d", c), 64'(bus.phase), 64'd1);
    end
    check("park_icount", 64'(bus.icount), 64'd1);
    bus.STEP = 1;
    tick();
    bus.STEP = 0;
    repeat (4) tick();
    check("step_retire", 64'(bus.retire), 64'd1);
    check("step_icount", 64'(bus.icount), 64'd2);
    tick();
    check("step_parked", 64'(bus.phase), 64'd1);
    bus.STEP_EN = 0;

    // Reset overrides stall mid-instruction
    do_reset();
    repeat (8) tick();
    check("pre_rst_phase", 64'(bus.phase), 64'd8);
    check("pre_rst_icount", 64'(bus.icount), 64'd1);
    bus.STALL = 1;
    rst = 1;
    tick();
    rst = 0;
    check("mid_rst_phase", 64'(bus.phase), 64'd1);
    check("mid_rst_icount", 64'(bus.icount), 64'd0);
    check("mid_rst_cycle", 64'(bus.cycle_cnt), 64'd0);
    bus.STALL = 0;

    // Narrow build: 4-bit icount wraps after 16 retires
    do_reset();
    repeat (45) tick();
    check("small_icount15", 64'(sbus.icount), 64'd15);
    check("small_retire45", 64'(sbus.retire), 64'd1);
    repeat (3) tick();
    check("small_icount_wrap", 64'(sbus.icount), 64'd0);
    check("small_retire48", 64'(sbus.retire), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
